// File: rtl/audio_addr_seq.sv
// audio_addr_seq: flash-audio word address sequencer and sample-lane unpacker.
// Define AUDIO_SEQ_UNDERRUN_EN to build the saturating sample-tick underrun counter.
module audio_addr_seq #(
    parameter int ADDR_W   = 23,
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_MIN = 0,
    parameter int ADDR_MAX = 'h7FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  play,
    input  logic                  forward,
    input  logic                  loop,
    input  logic                  restart,
    input  logic [3:0]            step,
    input  logic                  flash_done,
    input  logic [WORD_W-1:0]     flash_data,
    output logic                  flash_read,
    output logic [ADDR_W-1:0]     flash_addr,
    output logic [WORD_W/8-1:0]   byteenable,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  at_end,
    output logic                  busy,
    output logic [15:0]           underrun_cnt
);

    localparam int LANES  = WORD_W / SAMPLE_W;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [ADDR_W:0] MIN_X = (ADDR_W+1)'(ADDR_MIN);
    localparam logic [ADDR_W:0] MAX_X = (ADDR_W+1)'(ADDR_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EMIT,
        S_ADVANCE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [WORD_W-1:0]   r_word, w_word_nxt;
    logic [LANE_W-1:0]   r_lane_cnt, w_lane_cnt_nxt;
    logic [SAMPLE_W-1:0] r_sample, w_sample_nxt;
    logic                r_sample_valid, w_sample_valid_nxt;
    logic                r_at_end, w_at_end_nxt;
    logic                r_flash_read;
    logic                r_busy;

    logic [LANE_W-1:0]   w_lane;
    logic [ADDR_W:0]     w_step;
    logic [ADDR_W:0]     w_addr_x;
    logic [ADDR_W:0]     w_sum;
    logic                w_fwd_over;
    logic                w_rev_under;

    // One extra address bit keeps the bound comparisons free of wrap-around.
    always_comb begin
        w_lane      = forward ? r_lane_cnt : (LANE_W'(LANES - 1) - r_lane_cnt);
        w_step      = (step == 4'd0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(step);
        w_addr_x    = {1'b0, r_addr};
        w_sum       = w_addr_x + w_step;
        w_fwd_over  = (w_sum > MAX_X);
        w_rev_under = (w_addr_x < (MIN_X + w_step));
    end

    always_comb begin
        // NOTE: every next-value is given a default first so no branch can infer a latch.
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_word_nxt         = r_word;
        w_lane_cnt_nxt     = r_lane_cnt;
        w_sample_nxt       = r_sample;
        w_sample_valid_nxt = 1'b0;
        w_at_end_nxt       = 1'b0;

        if (restart) begin
            w_state_nxt    = S_IDLE;
            w_addr_nxt     = forward ? ADDR_W'(ADDR_MIN) : ADDR_W'(ADDR_MAX);
            w_lane_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (play) w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (flash_done) begin
                        w_word_nxt     = flash_data;
                        w_lane_cnt_nxt = '0;
                        w_state_nxt    = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (sample_tick) begin
                        w_sample_nxt       = r_word[w_lane*SAMPLE_W +: SAMPLE_W];
                        w_sample_valid_nxt = 1'b1;
                        w_lane_cnt_nxt     = r_lane_cnt + 1'b1;
                        if (r_lane_cnt == LANE_W'(LANES - 1)) w_state_nxt = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    w_state_nxt = play ? S_REQ : S_IDLE;
                    if (forward) begin
                        if (!w_fwd_over) begin
                            w_addr_nxt = w_sum[ADDR_W-1:0];
                        end else if (loop) begin
                            w_addr_nxt = ADDR_W'(ADDR_MIN);
                        end else begin
                            w_at_end_nxt = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        if (!w_rev_under) begin
                            w_addr_nxt = r_addr - w_step[ADDR_W-1:0];
                        end else if (loop) begin
                            w_addr_nxt = ADDR_W'(ADDR_MAX);
                        end else begin
                            w_at_end_nxt = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= ADDR_W'(ADDR_MIN);
            r_word         <= '0;
            r_lane_cnt     <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_at_end       <= 1'b0;
            r_flash_read   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_word         <= w_word_nxt;
            r_lane_cnt     <= w_lane_cnt_nxt;
            r_sample       <= w_sample_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_at_end       <= w_at_end_nxt;
            r_flash_read   <= (w_state_nxt == S_REQ);
            r_busy         <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef AUDIO_SEQ_UNDERRUN_EN
    logic [15:0] r_underrun;

    // Ticks that land while a word is still being fetched or addressed are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= '0;
        end else if (restart) begin
            r_underrun <= '0;
        end else if (sample_tick && play && (r_state == S_REQ || r_state == S_ADVANCE)
                     && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign flash_read   = r_flash_read;
    assign flash_addr   = r_addr;
    assign byteenable   = '1;
    assign sample_out   = r_sample;
    assign sample_valid = r_sample_valid;
    assign at_end       = r_at_end;
    assign busy         = r_busy;

endmodule

// File: tb/tb_audio_addr_seq.sv
// Bench for audio_addr_seq: directed corner cases plus randomized playback against a word/lane model.
module tb_audio_addr_seq;

    localparam int ADDR_W   = 23;
    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int ADDR_MIN = 0;
    localparam int ADDR_MAX = 'h7FFFF;
    localparam int LANES    = WORD_W / SAMPLE_W;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  sample_tick, play, forward, loop, restart, flash_done;
    logic [3:0]            step;
    logic [WORD_W-1:0]     flash_data;
    logic                  flash_read, sample_valid, at_end, busy;
    logic [ADDR_W-1:0]     flash_addr;
    logic [WORD_W/8-1:0]   byteenable;
    logic [SAMPLE_W-1:0]   sample_out;
    logic [15:0]           underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    audio_addr_seq #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SAMPLE_W(SAMPLE_W),
        .ADDR_MIN(ADDR_MIN), .ADDR_MAX(ADDR_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .play(play),
        .forward(forward), .loop(loop), .restart(restart), .step(step),
        .flash_done(flash_done), .flash_data(flash_data), .flash_read(flash_read),
        .flash_addr(flash_addr), .byteenable(byteenable), .sample_out(sample_out),
        .sample_valid(sample_valid), .at_end(at_end), .busy(busy),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (flash_read) break;
            clk1();
        end
        check(tag, flash_read, 1);
    endtask

    task automatic serve(input logic [WORD_W-1:0] d, input int dly);
        repeat (dly) clk1();
        flash_done = 1'b1;
        flash_data = d;
        clk1();
        flash_done = 1'b0;
    endtask

    task automatic tick_expect(input string tag, input logic [SAMPLE_W-1:0] exp);
        sample_tick = 1'b1;
        clk1();
        sample_tick = 1'b0;
        check({tag, "_valid"}, sample_valid, 1);
        check(tag, sample_out, exp);
    endtask

    task automatic do_restart(input logic dir);
        forward = dir;
        restart = 1'b1;
        clk1();
        restart = 1'b0;
    endtask

    // Reference: bounded address stepping with wrap or stop, computed in plain integers.
    function automatic int next_addr(input int a, input bit fwd, input int stp, input bit lp,
                                     output bit ended);
        int s = (stp == 0) ? 1 : stp;
        ended = 1'b0;
        if (fwd) begin
            if (a + s > ADDR_MAX) begin
                if (lp) return ADDR_MIN;
                ended = 1'b1;
                return a;
            end
            return a + s;
        end
        if (a < ADDR_MIN + s) begin
            if (lp) return ADDR_MAX;
            ended = 1'b1;
            return a;
        end
        return a - s;
    endfunction

    task automatic random_scenario(input int sc);
        logic [SAMPLE_W-1:0] exp_q[$];
        logic [WORD_W-1:0]   d;
        bit   fwd, lp, serving, expect_end, finished, ended;
        int   m_addr, stp, cnt, nlanes, words;

        flash_done = 1'b0;
        play       = 1'b0;
        do_restart(1'($urandom_range(0, 1)));
        m_addr = forward ? ADDR_MIN : ADDR_MAX;
        check("rnd_restart_addr", flash_addr, m_addr);

        fwd = 1'($urandom_range(0, 1));
        lp  = 1'($urandom_range(0, 1));
        stp = $urandom_range(0, 15);
        forward = fwd;
        loop    = lp;
        step    = 4'(stp);
        play    = 1'b1;
        serving = 0; cnt = 0; nlanes = 0; words = 0; expect_end = 0; finished = 0;

        for (int c = 0; c < 400 && !finished; c++) begin
            sample_tick = ($urandom_range(0, 2) == 0);
            flash_done  = 1'b0;
            if (serving && cnt == 0) begin
                d          = $urandom;
                flash_done = 1'b1;
                flash_data = d;
                for (int i = 0; i < LANES; i++) begin
                    int ln = fwd ? i : LANES - 1 - i;
                    exp_q.push_back(SAMPLE_W'(d >> (ln * SAMPLE_W)));
                end
            end else if (serving) begin
                cnt--;
            end
            clk1();
            if (flash_done) serving = 0;

            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_sample", sample_valid, 0);
                end else begin
                    check("rnd_sample", sample_out, exp_q.pop_front());
                    nlanes++;
                    if (nlanes == LANES) begin
                        nlanes = 0;
                        words++;
                        m_addr = next_addr(m_addr, fwd, stp, lp, ended);
                        if (ended) expect_end = 1;
                        else if (words >= 5) finished = 1;
                    end
                end
            end

            if (at_end) begin
                check("rnd_at_end_expected", expect_end, 1);
                check("rnd_end_addr", flash_addr, m_addr);
                check("rnd_end_busy", busy, 0);
                finished = 1;
            end

            if (flash_read && !serving && !finished) begin
                check("rnd_req_addr", flash_addr, m_addr);
                serving = 1;
                cnt     = $urandom_range(0, 3);
            end
        end
        if (!finished) check($sformatf("rnd_timeout_sc%0d", sc), finished, 1);
        sample_tick = 1'b0;
        flash_done  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sample_tick = 0; play = 0; forward = 1; loop = 1; restart = 0;
        flash_done = 0; step = 4'd1; flash_data = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        clk1();

        check("rst_flash_read", flash_read, 0);
        check("rst_flash_addr", flash_addr, ADDR_MIN);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_at_end", at_end, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("byteenable", byteenable, 4'hF);

        // Forward playback of one word, then the next request.
        play = 1'b1;
        clk1();
        check("fwd_read_rise", flash_read, 1);
        check("fwd_addr0", flash_addr, 0);
        serve(32'hAAAA5555, 3);
        check("fwd_read_fall", flash_read, 0);
        tick_expect("fwd_lane0", 16'h5555);
        tick_expect("fwd_lane1", 16'hAAAA);
        clk1();
        check("fwd_next_read", flash_read, 1);
        check("fwd_next_addr", flash_addr, 1);

        // Restart during a pending read, reversing to the upper bound.
        do_restart(1'b0);
        check("rs_read_drop", flash_read, 0);
        check("rs_addr", flash_addr, 'h7FFFF);
        check("rs_sample_hold", sample_out, 16'hAAAA);
        check("rs_busy", busy, 0);

        wait_read("rev_read");
        check("rev_addr", flash_addr, 'h7FFFF);
        serve(32'hAAAA5555, 3);
        tick_expect("rev_lane1", 16'hAAAA);
        tick_expect("rev_lane0", 16'h5555);
        clk1();
        check("rev_next_addr", flash_addr, 'h7FFFE);

        // From 7FFFE stepping 3 forward: wrap with loop set.
        forward = 1'b1; step = 4'd3; loop = 1'b1;
        serve(32'h12345678, 1);
        tick_expect("wrap_lane0", 16'h5678);
        tick_expect("wrap_lane1", 16'h1234);
        clk1();
        check("wrap_read", flash_read, 1);
        check("wrap_addr", flash_addr, 0);

        // Same move with loop clear: one-shot end.
        do_restart(1'b0);
        step = 4'd1;
        wait_read("os_read");
        serve(32'h11112222, 2);
        tick_expect("os_pre_lane1", 16'h1111);
        tick_expect("os_pre_lane0", 16'h2222);
        clk1();
        check("os_pre_addr", flash_addr, 'h7FFFE);
        forward = 1'b1; step = 4'd3; loop = 1'b0;
        serve(32'hCAFEF00D, 2);
        tick_expect("os_lane0", 16'hF00D);
        tick_expect("os_lane1", 16'hCAFE);
        play = 1'b0;
        clk1();
        check("os_at_end", at_end, 1);
        check("os_addr_hold", flash_addr, 'h7FFFE);
        check("os_busy", busy, 0);
        clk1();
        check("os_at_end_pulse", at_end, 0);

        // Pause mid-word: the word completes, then the sequencer idles.
        do_restart(1'b1);
        loop = 1'b1; step = 4'd1; play = 1'b1;
        wait_read("pause_read");
        check("pause_addr", flash_addr, 0);
        serve(32'h0BADBEEF, 1);
        tick_expect("pause_lane0", 16'hBEEF);
        play = 1'b0;
        tick_expect("pause_lane1", 16'h0BAD);
        clk1();
        check("pause_adv_addr", flash_addr, 1);
        check("pause_busy", busy, 0);
        repeat (5) clk1();
        check("pause_no_read", flash_read, 0);

        // Ticks while the fetch is withheld.
        do_restart(1'b1);
        play = 1'b1;
        wait_read("ur_read");
        repeat (4) begin
            sample_tick = 1'b1;
            clk1();
            sample_tick = 1'b0;
            clk1();
        end
        check("ur_still_reading", flash_read, 1);
`ifdef AUDIO_SEQ_UNDERRUN_EN
        check("ur_count", underrun_cnt, 4);
`else
        check("ur_count", underrun_cnt, 0);
`endif
        serve(32'h0, 0);
        play = 1'b0;
        do_restart(1'b1);
        check("ur_cleared", underrun_cnt, 0);

        for (int sc = 0; sc < 40; sc++) random_scenario(sc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
